// File: rtl/regfile_wr_arbiter.sv
// Write-port controller for the register file: WB has priority, multicycle results
// are queued or bypassed, and a pending scoreboard tracks in-flight destinations.
module regfile_wr_arbiter #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_we,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DW-1:0]            wb_data,
  input  logic                     mc_valid,
  output logic                     mc_ready,
  input  logic [AW-1:0]            mc_addr,
  input  logic [DW-1:0]            mc_data,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_addr,
  input  logic [AW-1:0]            chk_a,
  input  logic [AW-1:0]            chk_b,
  output logic                     busy_a,
  output logic                     busy_b,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_a3,
  output logic [DW-1:0]            rf_wd,
  output logic [$clog2(QDEPTH):0]  q_count,
  output logic                     err
);

  localparam int PW   = $clog2(QDEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 2 ** AW;

  logic [AW-1:0]   q_addr [QDEPTH];
  logic [DW-1:0]   q_data [QDEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic [NREG-1:0] pending, pend_nxt;

  logic            q_empty, accept, push, pop, byp;
  logic            sel_any, sel_mc, err_set;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  assign q_empty  = (cnt == '0);
  assign mc_ready = (cnt < CW'(QDEPTH));
  assign accept   = mc_valid & mc_ready;
  assign push     = accept & ~byp;
  assign q_count  = cnt;
  assign busy_a   = pending[chk_a];
  assign busy_b   = pending[chk_b];

  always_comb begin
    sel_any  = 1'b0;
    sel_mc   = 1'b0;
    pop      = 1'b0;
    byp      = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (wb_we) begin
      sel_any  = 1'b1;
      sel_addr = wb_addr;
      sel_data = wb_data;
    end else if (!q_empty) begin
      sel_any  = 1'b1;
      sel_mc   = 1'b1;
      pop      = 1'b1;
      sel_addr = q_addr[rd_ptr];
      sel_data = q_data[rd_ptr];
    end else if (accept) begin
      sel_any  = 1'b1;
      sel_mc   = 1'b1;
      byp      = 1'b1;
      sel_addr = mc_addr;
      sel_data = mc_data;
    end
  end

  // Register 0 is never written, but a queued or bypassed source is still consumed.
  assign rf_we = rst & sel_any & (sel_addr != '0);
  assign rf_a3 = sel_addr;
  assign rf_wd = sel_data;

  always_comb begin
    pend_nxt = pending;
    if (sel_mc)    pend_nxt[sel_addr] = 1'b0;
    if (iss_valid) pend_nxt[iss_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  assign err_set = (iss_valid & pending[iss_addr])
                 | (wb_we & pending[wb_addr])
                 | (sel_mc & (sel_addr != '0) & ~pending[sel_addr]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      pending <= '0;
      err     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      pending <= pend_nxt;
      if (err_set) err <= 1'b1;
    end
  end

  // Queue payload needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= mc_addr;
      q_data[wr_ptr] <= mc_data;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus constrained-random traffic,
// checked against a queue-based reference model through a write scoreboard.
module tb_regfile_wr_arbiter;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we, mc_valid, iss_valid;
  logic [4:0]  wb_addr, mc_addr, iss_addr, chk_a, chk_b;
  logic [31:0] wb_data, mc_data;
  logic        mc_ready, busy_a, busy_b, rf_we, err;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [1:0]  q_count;

  regfile_wr_arbiter #(.DW(32), .AW(5), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr), .mc_data(mc_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .chk_a(chk_a), .chk_b(chk_b), .busy_a(busy_a), .busy_b(busy_b),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .q_count(q_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  // Reference model state: result queue, pending set, sticky error.
  wr_t  mq[$];
  wr_t  exp_q[$];
  bit   m_pend [32];
  bit   m_err;

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;
  bit   last_acc;
  int   exp_qc;
  bit   exp_ready, exp_err, exp_ba, exp_bb, exp_idle;

  function automatic void check(string n, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, expv, $time);
    end
  endfunction

  // Monitor: pops an expected write whenever the DUT presents one.
  always @(negedge clk) begin
    if (chk_en) begin
      bit  exp_we;
      wr_t e;
      exp_we = (exp_q.size() > 0);
      check("rf_we", rf_we, exp_we);
      if (exp_we) begin
        e = exp_q.pop_front();
        if (rf_we === 1'b1) begin
          check("rf_a3", rf_a3, e.a);
          check("rf_wd", rf_wd, e.d);
        end
      end else if (exp_idle) begin
        check("idle_a3", rf_a3, 0);
        check("idle_wd", rf_wd, 0);
      end
      check("q_count", q_count, exp_qc);
      check("mc_ready", mc_ready, exp_ready);
      check("err", err, exp_err);
      check("busy_a", busy_a, exp_ba);
      check("busy_b", busy_b, exp_bb);
    end
  end

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_err = 0;
  endtask

  task automatic step(input bit w, input logic [4:0] wa, input logic [31:0] wd,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md,
                      input bit iv, input logic [4:0] ia,
                      input logic [4:0] ca, input logic [4:0] cb);
    wr_t h;
    bit  acc, wm, e;
    wr_t x;
    wb_we = w;  wb_addr = wa;  wb_data = wd;
    mc_valid = mv;  mc_addr = ma;  mc_data = md;
    iss_valid = iv;  iss_addr = ia;
    chk_a = ca;  chk_b = cb;
    exp_qc    = mq.size();
    exp_ready = (mq.size() < QD);
    exp_err   = m_err;
    exp_ba    = m_pend[ca];
    exp_bb    = m_pend[cb];
    exp_idle  = 0;
    acc = mv && exp_ready;
    last_acc = acc;
    wm = 0;  e = 0;
    x = '0;
    if (w) begin
      if (wa != 0) exp_q.push_back('{a: wa, d: wd});
      if (m_pend[wa]) e = 1;
    end else if (mq.size() > 0) begin
      x = mq.pop_front();
      wm = 1;
    end else if (acc) begin
      x = '{a: ma, d: md};
      wm = 1;
      acc = 0;
    end else begin
      exp_idle = 1;
    end
    if (acc) begin
      h = '{a: ma, d: md};
      mq.push_back(h);
    end
    if (wm) begin
      if (x.a != 0) exp_q.push_back(x);
      if (x.a != 0 && !m_pend[x.a]) e = 1;
    end
    if (iv && m_pend[ia]) e = 1;
    if (wm) m_pend[x.a] = 0;
    if (iv && ia != 0) m_pend[ia] = 1;
    if (e) m_err = 1;
    chk_en = 1;
    @(posedge clk); #1;
    chk_en = 0;
  endtask

  task automatic idle(input logic [4:0] ca);
    step(0, 0, 0, 0, 0, 0, 0, 0, ca, ca);
  endtask

  task automatic present(input logic [4:0] ma, input logic [31:0] md);
    bit done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      step(0, 0, 0, 1, ma, md, 0, 0, ma, 0);
      done = last_acc;
    end
    check("accept_bound", done, 1);
  endtask

  task automatic do_reset(input logic [4:0] ca);
    chk_en = 0;
    wb_we = 1;  wb_addr = 5'd3;  wb_data = 32'hA5A5_0003;
    mc_valid = 0;  mc_addr = 0;  mc_data = 0;
    iss_valid = 0;  iss_addr = 0;
    chk_a = ca;  chk_b = 0;
    rst = 0;
    #2;
    check("rst_q_count", q_count, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_mc_ready", mc_ready, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    wb_we = 0;
    rst = 1;
    model_clear();
  endtask

  initial begin
    wr_t  hb;
    bit   hv;
    int   outs[$];
    rst = 0;
    model_clear();
    #1;
    do_reset(0);

    // Bypass of a result into an idle port, then pending clears.
    step(0, 0, 0, 0, 0, 0, 1, 5, 5, 5);
    idle(5);
    idle(5);
    step(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
    idle(5);

    // WB keeps the port while results queue up; the third beat stalls.
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 8);
    step(0, 0, 0, 0, 0, 0, 1, 8, 7, 8);
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 8);
    step(1, 3, 32'h300, 1, 7, 1, 0, 0, 7, 9);
    step(1, 3, 32'h301, 1, 8, 2, 0, 0, 7, 9);
    for (int k = 0; k < 3; k++) step(1, 3, 32'h302 + k, 1, 9, 3, 0, 0, 7, 9);
    present(9, 3);
    for (int k = 0; k < 3; k++) idle(9);

    // Pop and push in the same cycle keeps occupancy at one.
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 8);
    step(0, 0, 0, 0, 0, 0, 1, 8, 7, 8);
    step(1, 2, 32'h22, 1, 7, 32'h70, 0, 0, 7, 8);
    step(0, 0, 0, 1, 8, 32'h80, 0, 0, 7, 8);
    idle(8);
    idle(8);

    // Register 0: consumed, never written, never pending.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h55, 0, 0, 0, 0);
    idle(0);

    // Protocol-respecting random traffic.
    hv = 0;  hb = '0;
    for (int i = 0; i < 3000; i++) begin
      bit          w, iv;
      logic [4:0]  wa, ia;
      int          idx;
      w  = ($urandom_range(0, 9) < 6);
      wa = 5'($urandom_range(0, 31));
      if (m_pend[wa]) w = 0;
      if (!hv && outs.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, outs.size() - 1);
        hb.a = 5'(outs[idx]);
        hb.d = $urandom;
        outs.delete(idx);
        hv = 1;
      end
      iv = ($urandom_range(0, 3) == 0);
      ia = 5'($urandom_range(0, 31));
      if (m_pend[ia]) iv = 0;
      step(w, wa, $urandom, hv, hb.a, hb.d, iv, ia,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (hv && last_acc) hv = 0;
      if (iv) outs.push_back(int'(ia));
    end
    while (hv) begin
      present(hb.a, hb.d);
      hv = 0;
    end
    for (int k = 0; k < 4; k++) idle(0);

    // Reset with a full queue and live pending entries.
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 8);
    step(0, 0, 0, 0, 0, 0, 1, 8, 7, 8);
    step(1, 3, 1, 1, 7, 32'h11, 0, 0, 7, 8);
    step(1, 3, 2, 1, 8, 32'h12, 0, 0, 7, 8);
    step(1, 3, 3, 0, 0, 0, 0, 0, 7, 8);
    do_reset(7);
    idle(7);

    // Error cases, each from a clean reset.
    step(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
    step(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
    idle(4);
    do_reset(4);
    step(0, 0, 0, 0, 0, 0, 1, 6, 6, 0);
    step(1, 6, 32'h1234, 0, 0, 0, 0, 0, 6, 0);
    idle(6);
    do_reset(10);
    step(0, 0, 0, 1, 10, 32'h77, 0, 0, 10, 0);
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
